// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file with write-through read bypass
// and a retired-instruction counter. Define WB_DEBUG_PORT_EN to add the dbgaddr/dbgdata read port.
module wb_regfile #(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter logic [4:0] XP_REG   = 5'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructionin,
  input  logic [31:0] rdatain,
  input  logic [31:0] ALUresultin,
  input  logic [31:0] linkin,
  input  logic [1:0]  RegDstin,
  input  logic        RegWrin,
  input  logic [1:0]  MemtoRegin,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [4:0]  wbaddr,
  output logic [31:0] wbdata,
  output logic        wben,
  output logic [31:0] retired
`ifdef WB_DEBUG_PORT_EN
  ,
  input  logic [4:0]  dbgaddr,
  output logic [31:0] dbgdata
`endif
);

  logic [31:0] r_regs [32];
  logic [31:0] r_retired;
  logic [4:0]  w_dest;
  logic [31:0] w_data;
  logic        w_wen;

  always_comb begin
    w_dest = instructionin[20:16];
    case (RegDstin)
      2'b00:   w_dest = instructionin[20:16];
      2'b01:   w_dest = instructionin[15:11];
      2'b10:   w_dest = LINK_REG;
      default: w_dest = XP_REG;
    endcase
  end

  always_comb begin
    w_data = ALUresultin;
    case (MemtoRegin)
      2'b01:   w_data = rdatain;
      2'b10:   w_data = linkin;
      default: w_data = ALUresultin;
    endcase
  end

  // reset gates the enable so neither the write nor the bypass happens during reset
  assign w_wen   = RegWrin & (w_dest != 5'd0) & reset;
  assign wbaddr  = w_dest;
  assign wbdata  = w_data;
  assign wben    = w_wen;
  assign retired = r_retired;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_retired <= '0;
    end else begin
      if (w_wen) begin
        r_regs[w_dest] <= w_data;
      end
      if (instructionin != 32'h0) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  always_comb begin
    rdata1 = r_regs[raddr1];
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (w_wen && (raddr1 == w_dest)) begin
      rdata1 = w_data;
    end
  end

  always_comb begin
    rdata2 = r_regs[raddr2];
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (w_wen && (raddr2 == w_dest)) begin
      rdata2 = w_data;
    end
  end

`ifdef WB_DEBUG_PORT_EN
  assign dbgdata = (dbgaddr == 5'd0) ? '0 : r_regs[dbgaddr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases followed by randomized traffic
// compared against an array-based reference model of the register file.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instructionin, rdatain, ALUresultin, linkin;
  logic [1:0]  RegDstin, MemtoRegin;
  logic        RegWrin;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, wbdata, retired;
  logic [4:0]  wbaddr;
  logic        wben;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_retired;

  always #5 clk = ~clk;

  wb_regfile #(.LINK_REG(5'd31), .XP_REG(5'd26)) dut (
    .clk(clk), .reset(reset), .instructionin(instructionin), .rdatain(rdatain),
    .ALUresultin(ALUresultin), .linkin(linkin), .RegDstin(RegDstin), .RegWrin(RegWrin),
    .MemtoRegin(MemtoRegin), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
    .rdata2(rdata2), .wbaddr(wbaddr), .wbdata(wbdata), .wben(wben), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_dest();
    case (RegDstin)
      2'd0: return instructionin[20:16];
      2'd1: return instructionin[15:11];
      2'd2: return 5'd31;
      default: return 5'd26;
    endcase
  endfunction

  function automatic logic [31:0] m_data();
    if (MemtoRegin == 2'd1) return rdatain;
    if (MemtoRegin == 2'd2) return linkin;
    return ALUresultin;
  endfunction

  function automatic logic m_wen();
    return RegWrin && (m_dest() != 5'd0) && reset;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (m_wen() && a == m_dest()) return m_data();
    return m_regs[a];
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [31:0] lnk, input logic [1:0] rdst, input logic wr,
                       input logic [1:0] m2r, input logic [4:0] a1, input logic [4:0] a2);
    instructionin = ins; rdatain = rd; ALUresultin = alu; linkin = lnk;
    RegDstin = rdst; RegWrin = wr; MemtoRegin = m2r; raddr1 = a1; raddr2 = a2;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wbaddr"},  {27'd0, wbaddr}, {27'd0, m_dest()});
    check({tag, ".wbdata"},  wbdata, m_data());
    check({tag, ".wben"},    {31'd0, wben}, {31'd0, m_wen()});
    check({tag, ".rdata1"},  rdata1, m_read(raddr1));
    check({tag, ".rdata2"},  rdata2, m_read(raddr2));
    check({tag, ".retired"}, retired, m_retired);
  endtask

  // reference-model update uses the inputs that are stable across the edge
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_retired = 32'h0;
    end else begin
      if (m_wen()) m_regs[m_dest()] = m_data();
      if (instructionin != 32'h0) m_retired = m_retired + 32'd1;
    end
    #1;
  endtask

  // read a register through port 1 with writes disabled and a NOP in flight
  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, a, a);
    check(tag, rdata1, exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_retired = 32'h0;
    reset = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 5'd0, 5'd0);
    tick();

    // reset held: write enable and bypass are suppressed
    drive(32'h0005_0000, 32'h0, 32'h99, 32'h0, 2'd0, 1'b1, 2'd0, 5'd5, 5'd5);
    check("rst_wben", {31'd0, wben}, 32'd0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_retired", retired, 32'h0);
    check_model("rst");
    tick();
    reset = 1'b1;

    // reg5 = 0x1234, then bring retired to 3, then reset clears both
    drive(32'h0005_0000, 32'h0, 32'h1234, 32'h0, 2'd0, 1'b1, 2'd0, 5'd5, 5'd1);
    check_model("w5");
    tick();
    drive(32'h1111_1111, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 5'd5, 5'd5);
    tick();
    tick();
    peek("r5_before_rst", 5'd5, 32'h1234);
    check("retired_3", retired, 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    peek("r5_after_rst", 5'd5, 32'h0);
    check("retired_cleared", retired, 32'h0);

    // RegDst=01 / MemtoReg=01 -> reg8 from read data
    drive(32'h0000_4000, 32'hCAFE_BABE, 32'h1, 32'h2, 2'd1, 1'b1, 2'd1, 5'd0, 5'd0);
    check("rd8_wbaddr", {27'd0, wbaddr}, 32'd8);
    tick();
    peek("reg8", 5'd8, 32'hCAFE_BABE);

    // RegDst=10 / MemtoReg=10 -> link register from linkin
    drive(32'h0C00_0000, 32'h3, 32'h4, 32'h0040_0010, 2'd2, 1'b1, 2'd2, 5'd0, 5'd0);
    check("link_wbaddr", {27'd0, wbaddr}, 32'd31);
    tick();
    peek("reg31", 5'd31, 32'h0040_0010);

    // RegDst=11 / reserved MemtoReg=11 -> exception register from ALU result
    drive(32'h4200_0018, 32'h5, 32'hDEAD_0001, 32'h6, 2'd3, 1'b1, 2'd3, 5'd0, 5'd0);
    check("xp_wbdata", wbdata, 32'hDEAD_0001);
    tick();
    peek("reg26", 5'd26, 32'hDEAD_0001);

    // writes to register 0 are discarded
    drive(32'h2000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'd0, 1'b1, 2'd0, 5'd0, 5'd0);
    check("zero_wben", {31'd0, wben}, 32'd0);
    check("zero_pre", rdata1, 32'h0);
    tick();
    peek("zero_post", 5'd0, 32'h0);

    // same-cycle bypass on both ports, then a non-write returns the stored value
    drive(32'h2009_0000, 32'h0, 32'h55, 32'h0, 2'd0, 1'b1, 2'd0, 5'd9, 5'd9);
    check("byp_rdata1", rdata1, 32'h55);
    check("byp_rdata2", rdata2, 32'h55);
    tick();
    drive(32'h2009_0000, 32'h0, 32'h77, 32'h0, 2'd0, 1'b0, 2'd0, 5'd9, 5'd9);
    check("nobyp_rdata1", rdata1, 32'h55);
    check("nobyp_rdata2", rdata2, 32'h55);
    tick();

    // reset coincident with a write drops it
    drive(32'h2003_0000, 32'h0, 32'h7, 32'h0, 2'd0, 1'b1, 2'd0, 5'd3, 5'd3);
    reset = 1'b0;
    #1;
    check("midrst_wben", {31'd0, wben}, 32'd0);
    tick();
    reset = 1'b1;
    peek("midrst_reg3", 5'd3, 32'h0);
    check("midrst_retired", retired, 32'h0);

    // 4 real instructions and 2 NOPs -> 4 retired
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? 32'h0000_0020 + i : 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 5'd0, 5'd0);
      tick();
    end
    check("retired_4", retired, 32'd4);

    // counter wrap from all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_retired = 32'hFFFF_FFFF;
    check("retired_max", retired, 32'hFFFF_FFFF);
    drive(32'h0000_0020, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 5'd0, 5'd0);
    tick();
    check("retired_wrap", retired, 32'h0);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [4:0]  a1, a2;
      ins = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      a1 = 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      reset = ($urandom_range(0, 39) != 0);
      drive(ins, $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom_range(0, 3) != 0),
            2'($urandom), a1, a2);
      if ($urandom_range(0, 2) == 0) begin
        raddr1 = m_dest();
        #1;
      end
      check_model("rnd");
      tick();
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
